// File: rtl/remote_tx.sv
// Quiz-remote transmitter: debounces eight active-low buttons and sends each clean
// single-button press as a serial frame (start, 8 data LSB first, odd parity, stop).
module remote_tx #(
    parameter int CLK_DIV  = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_n,
    output logic       tx,
    output logic       busy,
    output logic       sent,
    output logic [7:0] code_out
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    sync1, sync2;
    logic [7:0]    stb, stb_next, stb_inv;
    logic [7:0]    shreg;
    logic [DW-1:0] db_cnt, db_next;
    logic [CW-1:0] div_cnt;
    logic [2:0]    state;
    logic [2:0]    bit_idx;
    logic          armed;
    logic          one_low;
    logic          accept;
    logic          div_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // sync1 is the next value of sync2, so equality means sync2 held another cycle.
    always_comb begin
        db_next = db_cnt;
        if (sync1 != sync2) begin
            db_next = '0;
        end else if (db_cnt != DB_MAX) begin
            db_next = db_cnt + DW'(1);
        end
    end

    // Acceptance looks at the stable vector being loaded this edge, not the old one.
    assign stb_next = (db_next == DB_MAX) ? sync2 : stb;
    assign stb_inv  = ~stb_next;
    assign one_low  = (stb_inv != 8'h00) && ((stb_inv & (stb_inv - 8'h01)) == 8'h00);
    assign accept   = (state == S_IDLE) && armed && one_low;
    assign div_done = (div_cnt == DIV_LAST);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            stb    <= 8'hFF;
            armed  <= 1'b1;
        end else begin
            db_cnt <= db_next;
            stb    <= stb_next;
            if (accept) begin
                armed <= 1'b0;
            end else if (stb_next == 8'hFF) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            sent     <= 1'b0;
            code_out <= 8'hFF;
            shreg    <= 8'hFF;
            div_cnt  <= '0;
            bit_idx  <= '0;
        end else begin
            sent <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        state    <= S_START;
                        tx       <= 1'b0;
                        div_cnt  <= '0;
                        shreg    <= stb_next;
                        code_out <= stb_next;
                    end
                end
                S_START: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shreg[0];
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_PARITY;
                            tx    <= ~^code_out;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b1, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= S_STOP;
                        tx      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= S_IDLE;
                        tx      <= 1'b1;
                        sent    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
